flags_resolve: RTL
==================

FLAGS_RESOLVE -- requirements
Module: flags_resolve

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of buffered flag entries (power of two, at least 2).
REQ-002 SHALL have parameter TAG_W, default 5, meaning the instruction tag width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port IN_valid, input, 1 bit: a flag entry is offered.
REQ-006 SHALL have port IN_flags, input, 4 bits: the entry's Flags value.
REQ-007 SHALL have port IN_tag, input, TAG_W bits: the tag of the producing instruction.
REQ-008 SHALL have port OUT_ready, output, 1 bit: the buffer can accept an entry.
REQ-009 SHALL have ports OUT_predValid (1 bit), OUT_predTaken (1 bit) and OUT_predTag (TAG_W bits), all outputs: direction-predictor update.
REQ-010 SHALL have ports OUT_flushValid (1 bit) and OUT_flushTag (TAG_W bits) as outputs, and IN_flushAck (1 bit) as input: the flush request handshake.
REQ-011 SHALL have ports OUT_trapValid (1 bit), OUT_trapCause (4 bits) and OUT_trapTag (TAG_W bits) as outputs, and IN_trapAck (1 bit) as input: the trap request handshake.
REQ-012 SHALL have port OUT_nxErr, output, 1 bit: one-cycle pulse when a FLAGS_NX entry is dequeued.

Function
REQ-013 SHALL use the Flags encoding NONE=0, BRANCH=1, PRED_TAKEN=2, PRED_NTAKEN=3, FENCE=4, ORDERING=5, ILLEGAL_INSTR=6, TRAP=7, LD_MA..ST_PF=8..13, XRET=14, NX=15.
REQ-014 SHALL accept an entry on a clock edge when IN_valid and OUT_ready are both 1; OUT_ready SHALL be 1 exactly when the registered occupancy is below DEPTH, with no dependence on same-cycle dequeue.
REQ-015 SHALL keep entries in FIFO order, with read and write pointers wrapping modulo DEPTH and an occupancy count of clog2(DEPTH)+1 bits.
REQ-016 SHALL have FSM states IDLE, FLUSH_WAIT and TRAP_WAIT; only IDLE examines or dequeues the head entry, at most one per cycle.
REQ-017 In IDLE with head NONE or BRANCH, SHALL dequeue the entry with no output.
REQ-018 In IDLE with head NX, SHALL dequeue the entry and pulse OUT_nxErr for one cycle.
REQ-019 In IDLE with head PRED_TAKEN or PRED_NTAKEN, SHALL dequeue the entry and register OUT_predValid=1 for exactly one cycle, with OUT_predTaken=1 for PRED_TAKEN, and OUT_predTag equal to the entry tag.
REQ-020 In IDLE with head FENCE or ORDERING, SHALL register OUT_flushValid=1 and OUT_flushTag equal to the entry tag, then go to FLUSH_WAIT.
REQ-021 In IDLE with head code 6..14, SHALL register OUT_trapValid=1, OUT_trapCause equal to the Flags value and OUT_trapTag equal to the entry tag, then go to TRAP_WAIT.
REQ-022 In FLUSH_WAIT/TRAP_WAIT, the request outputs SHALL stay stable until the edge that samples the matching ack high, deassert after that edge, and the state SHALL return to IDLE.
REQ-023 On the ack edge, SHALL discard the head entry and all younger buffered entries (occupancy becomes 0); an entry offered in that same cycle SHALL be dropped even if OUT_ready=1.
REQ-024 SHALL ignore IN_flushAck and IN_trapAck outside their matching wait state.
REQ-025 Latency: an entry accepted at edge E0 SHALL reach the head in the next cycle; its predictor pulse, flush request or trap request SHALL become visible after edge E1.
REQ-026 SHALL keep accepting entries during the wait states until the buffer is full.

Reset
REQ-027 While rst_n=0, SHALL asynchronously force occupancy 0 and pointers 0, state IDLE, and all valid/pulse outputs and tag/cause outputs to 0; OUT_ready SHALL be 1 after reset.
REQ-028 Reset asserted during FLUSH_WAIT/TRAP_WAIT SHALL abandon the pending request without requiring an ack.

Structure
REQ-029 The Flags enum, and a classification function mapping Flags to one of {drop, nx, pred, flush, trap}, SHALL live in shared package flags_pkg.
REQ-030 The buffer SHALL be a sub-module flags_fifo (parameters DEPTH and width) with push, pop, clear, full and empty.

Verification
REQ-031 Push PRED_NTAKEN with tag 3 -> after E1, exactly one cycle with OUT_predValid=1, OUT_predTaken=0, OUT_predTag=3.
REQ-032 Push FENCE tag 7, then BRANCH tag 8, with ack held low for 5 cycles -> OUT_flushValid=1 with tag 7 held for 5 cycles; after the ack, occupancy is 0 and BRANCH produces no output.
REQ-033 Push ST_PF tag 2 -> OUT_trapCause=13 and OUT_trapTag=2 held until IN_trapAck; offer tag 9 in the ack cycle -> it is dropped.
REQ-034 Hold a trap unacked and offer 5 entries with DEPTH=4 -> OUT_ready falls after the 4th acceptance and the 5th is not accepted.
REQ-035 Push NX -> one OUT_nxErr pulse; assert IN_flushAck while IDLE -> no state change.
REQ-036 Assert rst_n=0 mid FLUSH_WAIT -> all outputs go to 0 immediately and OUT_ready=1 after release.

Source files
------------

// File: rtl/flags_pkg.sv
// flags_pkg: Flags encoding and the per-entry action classification shared by
// the flag resolver and its buffer.
package flags_pkg;
   typedef enum logic [3:0] {
      FLAGS_NONE, FLAGS_BRANCH, FLAGS_PRED_TAKEN, FLAGS_PRED_NTAKEN,
      FLAGS_FENCE, FLAGS_ORDERING, FLAGS_ILLEGAL_INSTR, FLAGS_TRAP,
      FLAGS_LD_MA, FLAGS_LD_AF, FLAGS_LD_PF, FLAGS_ST_MA, FLAGS_ST_AF, FLAGS_ST_PF,
      FLAGS_XRET, FLAGS_NX
   } flags_t;

   typedef enum logic [2:0] {CLS_DROP, CLS_NX, CLS_PRED, CLS_FLUSH, CLS_TRAP} flag_cls_t;

   function automatic flag_cls_t classify(input flags_t f);
      return (f == FLAGS_NONE || f == FLAGS_BRANCH) ? CLS_DROP :
             (f == FLAGS_NX) ? CLS_NX :
             (f == FLAGS_PRED_TAKEN || f == FLAGS_PRED_NTAKEN) ? CLS_PRED :
             (f == FLAGS_FENCE || f == FLAGS_ORDERING) ? CLS_FLUSH : CLS_TRAP;
   endfunction
endpackage

// File: rtl/flags_fifo.sv
// flags_fifo: power-of-two FIFO with registered occupancy and a clear that
// discards every buffered entry and wins over a simultaneous push.
module flags_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         clear,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic          push_ok, pop_ok;

   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign dout    = mem[rd_ptr];
   assign push_ok = push && !full && !clear;
   assign pop_ok  = pop && !empty && !clear;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push_ok);
         rd_ptr <= rd_ptr + AW'(pop_ok);
         count  <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end

   always_ff @(posedge clk)
      if (push_ok) mem[wr_ptr] <= din;
endmodule

// File: rtl/flags_resolve.sv
// flags_resolve: drains buffered instruction flags in order, turning each into a
// predictor update, an NX pulse, or a flush/trap request held until acknowledged.
module flags_resolve
   import flags_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             IN_valid,
   input  logic [3:0]       IN_flags,
   input  logic [TAG_W-1:0] IN_tag,
   output logic             OUT_ready,
   output logic             OUT_predValid,
   output logic             OUT_predTaken,
   output logic [TAG_W-1:0] OUT_predTag,
   output logic             OUT_flushValid,
   output logic [TAG_W-1:0] OUT_flushTag,
   input  logic             IN_flushAck,
   output logic             OUT_trapValid,
   output logic [3:0]       OUT_trapCause,
   output logic [TAG_W-1:0] OUT_trapTag,
   input  logic             IN_trapAck,
   output logic             OUT_nxErr
);
   typedef enum logic [1:0] {IDLE, FLUSH_WAIT, TRAP_WAIT} state_t;

   state_t           state, state_nx;
   logic [TAG_W+3:0] head;
   flags_t           head_flags;
   logic [TAG_W-1:0] head_tag;
   flag_cls_t        cls;
   logic             full, empty, push, pop, clear;

   assign head_flags = flags_t'(head[3:0]);
   assign head_tag   = head[TAG_W+3:4];
   assign cls        = classify(head_flags);
   assign clear      = (state == FLUSH_WAIT && IN_flushAck) || (state == TRAP_WAIT && IN_trapAck);
   // The head leaves the buffer as soon as it is examined; flush/trap payloads live on in the output registers.
   assign pop        = state == IDLE && !empty;
   assign push       = IN_valid && !full && !clear;
   assign OUT_ready  = !full;

   flags_fifo #(.DEPTH(DEPTH), .W(TAG_W + 4)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .clear (clear),
      .din   ({IN_tag, IN_flags}),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   always_comb begin
      state_nx = clear ? IDLE :
                 !pop ? state :
                 cls == CLS_FLUSH ? FLUSH_WAIT :
                 cls == CLS_TRAP ? TRAP_WAIT : IDLE;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         OUT_predValid  <= 1'b0;
         OUT_predTaken  <= 1'b0;
         OUT_predTag    <= '0;
         OUT_nxErr      <= 1'b0;
         OUT_flushValid <= 1'b0;
         OUT_flushTag   <= '0;
         OUT_trapValid  <= 1'b0;
         OUT_trapCause  <= '0;
         OUT_trapTag    <= '0;
      end else begin
         OUT_predValid <= pop && cls == CLS_PRED;
         OUT_nxErr     <= pop && cls == CLS_NX;
         if (pop && cls == CLS_PRED) begin
            OUT_predTaken <= head_flags == FLAGS_PRED_TAKEN;
            OUT_predTag   <= head_tag;
         end
         if (pop && cls == CLS_FLUSH) begin
            OUT_flushValid <= 1'b1;
            OUT_flushTag   <= head_tag;
         end else if (clear) OUT_flushValid <= 1'b0;
         if (pop && cls == CLS_TRAP) begin
            OUT_trapValid <= 1'b1;
            OUT_trapCause <= head[3:0];
            OUT_trapTag   <= head_tag;
         end else if (clear) OUT_trapValid <= 1'b0;
      end
endmodule
